// File: rtl/mult_cell_pipelined.sv
// Pipelined split-operand multiplier cell: registered partial products plus the low DATA_W product.
// Define MULT_CELL_HIGH_PRODUCT_EN to add mul_signed, p4 and result_hi (upper half of the full product).
module mult_cell_pipelined #(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
`ifdef MULT_CELL_HIGH_PRODUCT_EN
  input  logic              mul_signed,
  output logic [DATA_W-1:0] p4,
  output logic [DATA_W-1:0] result_hi,
`endif
  output logic              out_valid,
  output logic [DATA_W-1:0] p1,
  output logic [DATA_W-1:0] p2,
  output logic [DATA_W-1:0] p3,
  output logic [DATA_W-1:0] result_lo
);

  localparam int HALF_W = DATA_W / 2;
`ifdef MULT_CELL_HIGH_PRODUCT_EN
  localparam int SUM_W = DATA_W + 2;
`else
  localparam int SUM_W = DATA_W;
`endif

  if (LATENCY != 2 && LATENCY != 3) begin : g_bad_latency
    $fatal(1, "mult_cell_pipelined: LATENCY must be 2 or 3");
  end
  if (DATA_W < 8 || (DATA_W % 2) != 0) begin : g_bad_width
    $fatal(1, "mult_cell_pipelined: DATA_W must be even and at least 8");
  end

  logic [DATA_W-1:0] a_q, b_q;
  logic              va;
`ifdef MULT_CELL_HIGH_PRODUCT_EN
  logic              sgn_a;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      va  <= 1'b0;
`ifdef MULT_CELL_HIGH_PRODUCT_EN
      sgn_a <= 1'b0;
`endif
    end else begin
      if (en) begin
        a_q <= src1;
        b_q <= src2;
`ifdef MULT_CELL_HIGH_PRODUCT_EN
        sgn_a <= mul_signed;
`endif
      end
      if (flush)
        va <= 1'b0;
      else if (en)
        va <= in_valid;
    end
  end

  // Zero-extended halves so every partial product is exact in DATA_W bits.
  logic [DATA_W-1:0] a_lo, a_hi, b_lo, b_hi;
  assign a_lo = {{HALF_W{1'b0}}, a_q[HALF_W-1:0]};
  assign a_hi = {{HALF_W{1'b0}}, a_q[DATA_W-1:HALF_W]};
  assign b_lo = {{HALF_W{1'b0}}, b_q[HALF_W-1:0]};
  assign b_hi = {{HALF_W{1'b0}}, b_q[DATA_W-1:HALF_W]};

  logic [DATA_W-1:0] pb1, pb2, pb3;
  logic              vb;
`ifdef MULT_CELL_HIGH_PRODUCT_EN
  logic [DATA_W-1:0] pb4, ab_q, bb_q;
  logic              sgn_b;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pb1 <= '0;
      pb2 <= '0;
      pb3 <= '0;
      vb  <= 1'b0;
`ifdef MULT_CELL_HIGH_PRODUCT_EN
      pb4   <= '0;
      ab_q  <= '0;
      bb_q  <= '0;
      sgn_b <= 1'b0;
`endif
    end else begin
      if (en) begin
        pb1 <= a_lo * b_lo;
        pb2 <= a_lo * b_hi;
        pb3 <= a_hi * b_lo;
`ifdef MULT_CELL_HIGH_PRODUCT_EN
        pb4   <= a_hi * b_hi;
        ab_q  <= a_q;
        bb_q  <= b_q;
        sgn_b <= sgn_a;
`endif
      end
      if (flush)
        vb <= 1'b0;
      else if (en)
        vb <= va;
    end
  end

  // Low-half sum is kept two bits wider when the high product needs its carry out.
  logic [SUM_W-1:0]  low_sum_b;
  logic [DATA_W-1:0] lo_b;
  assign low_sum_b = SUM_W'(pb1)
                   + (SUM_W'(pb2[HALF_W-1:0]) << HALF_W)
                   + (SUM_W'(pb3[HALF_W-1:0]) << HALF_W);
  assign lo_b = low_sum_b[DATA_W-1:0];

`ifdef MULT_CELL_HIGH_PRODUCT_EN
  logic [DATA_W-1:0] hi_raw_b, hi_b;

  // Signed correction: subtract each operand wherever the other one is negative.
  always_comb begin
    hi_raw_b = pb4 + (pb2 >> HALF_W) + (pb3 >> HALF_W)
             + {{(DATA_W-2){1'b0}}, low_sum_b[DATA_W+1:DATA_W]};
    hi_b = hi_raw_b;
    if (sgn_b && ab_q[DATA_W-1])
      hi_b = hi_b - bb_q;
    if (sgn_b && bb_q[DATA_W-1])
      hi_b = hi_b - ab_q;
  end
`endif

  if (LATENCY == 3) begin : g_stage_c
    logic [DATA_W-1:0] pc1, pc2, pc3, loc;
    logic              vc;
`ifdef MULT_CELL_HIGH_PRODUCT_EN
    logic [DATA_W-1:0] pc4, hic;
`endif

    always_ff @(posedge clk) begin
      if (reset) begin
        pc1 <= '0;
        pc2 <= '0;
        pc3 <= '0;
        loc <= '0;
        vc  <= 1'b0;
`ifdef MULT_CELL_HIGH_PRODUCT_EN
        pc4 <= '0;
        hic <= '0;
`endif
      end else begin
        if (en) begin
          pc1 <= pb1;
          pc2 <= pb2;
          pc3 <= pb3;
          loc <= lo_b;
`ifdef MULT_CELL_HIGH_PRODUCT_EN
          pc4 <= pb4;
          hic <= hi_b;
`endif
        end
        if (flush)
          vc <= 1'b0;
        else if (en)
          vc <= vb;
      end
    end

    assign out_valid = vc;
    assign p1        = pc1;
    assign p2        = pc2;
    assign p3        = pc3;
    assign result_lo = loc;
`ifdef MULT_CELL_HIGH_PRODUCT_EN
    assign p4        = pc4;
    assign result_hi = hic;
`endif
  end else begin : g_stage_b_out
    assign out_valid = vb;
    assign p1        = pb1;
    assign p2        = pb2;
    assign p3        = pb3;
    assign result_lo = lo_b;
`ifdef MULT_CELL_HIGH_PRODUCT_EN
    assign p4        = pb4;
    assign result_hi = hi_b;
`endif
  end

endmodule
